window_3x3_gen: RTL

//   Converts a raster-order 8-bit pixel stream into 3x3 neighbourhood windows, packed 72 bits

---
 rtl/window_3x3_gen_if.sv | 20 ++
 rtl/window_3x3_gen.sv | 126 ++++++++++++
 2 files changed

// File: rtl/window_3x3_gen_if.sv
// Pixel-stream in / 3x3-window stream out bundle for window_3x3_gen.
// The master side feeds pixels and consumes windows; the slave side is the generator.
interface window_3x3_gen_if;
    logic [7:0]  i_pixel;
    logic        i_pixel_valid;
    logic        i_sof;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_frame_done;

    modport master (
        output i_pixel, i_pixel_valid, i_sof,
        input  o_pixel_data, o_pixel_data_valid, o_frame_done
    );

    modport slave (
        input  i_pixel, i_pixel_valid, i_sof,
        output o_pixel_data, o_pixel_data_valid, o_frame_done
    );
endinterface

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood window generator for a raster pixel stream.
// Two line buffers supply the two lines above the incoming pixel; a 3x3 shift
// register assembles the window. Only fully-populated windows are flagged valid,
// so the output image is (IMG_WIDTH-2) x (IMG_HEIGHT-2).
module window_3x3_gen #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    window_3x3_gen_if.slave pix
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_q, col_cur, col_nxt;
    logic [RW-1:0] row_q, row_cur, row_nxt;

    // Line buffers are plain RAM: no reset, stale rows are hidden by the row gate.
    logic [7:0] lb0 [IMG_WIDTH];
    logic [7:0] lb1 [IMG_WIDTH];
    logic [7:0] top_px, mid_px;

    logic [7:0]  win [3][3];
    logic [71:0] win_packed;
    logic        valid_q, done_q;
    logic        full_win, last_px;

    // Position of the current pixel; sof forces (0,0) regardless of counter state.
    always_comb begin
        col_cur = pix.i_sof ? '0 : col_q;
        row_cur = pix.i_sof ? '0 : row_q;
    end

    // Raster counter advance, wrapping at end of line and end of frame.
    always_comb begin
        col_nxt = col_q;
        row_nxt = row_q;
        if (pix.i_pixel_valid) begin
            if (col_cur == COL_LAST) begin
                col_nxt = '0;
                row_nxt = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
            end else begin
                col_nxt = col_cur + 1'b1;
                row_nxt = row_cur;
            end
        end
    end

    // Window gating: interior positions only, plus end-of-frame marker.
    always_comb begin
        full_win = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
        last_px  = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
    end

    // Column/row counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_nxt;
            row_q <= row_nxt;
        end
    end

    // Read-before-write line buffers: reads see the two previous lines at this column.
    always_comb begin
        top_px = lb1[col_cur];
        mid_px = lb0[col_cur];
    end

    // Push the new pixel into LB0 and the displaced LB0 entry into LB1.
    always_ff @(posedge i_clk) begin
        if (pix.i_pixel_valid) begin
            lb1[col_cur] <= lb0[col_cur];
            lb0[col_cur] <= pix.i_pixel;
        end
    end

    // Window shift register: columns move left, new right column is {top, mid, pixel}.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (pix.i_pixel_valid) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= top_px;
            win[1][2] <= mid_px;
            win[2][2] <= pix.i_pixel;
        end
    end

    // Single-cycle strobes, cleared on any idle cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= pix.i_pixel_valid && full_win;
            done_q  <= pix.i_pixel_valid && last_px;
        end
    end

    // Pack window: byte (3*row + col), so byte 0 is the oldest top-left pixel.
    always_comb begin
        win_packed = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_packed[(r*3 + c)*8 +: 8] = win[r][c];
            end
        end
    end

    assign pix.o_pixel_data       = win_packed;
    assign pix.o_pixel_data_valid = valid_q;
    assign pix.o_frame_done       = done_q;
endmodule
